ext_ram_burst_ctrl: RTL
=======================

// Module: ext_ram_burst_ctrl
// PURPOSE
// - Initiator side of the single-port sync RAM (cs/we/address/data_in/data_out, 1-cycle registered read).
// - Turns burst requests from the LDPC decoder datapath into per-word RAM accesses.
// - Streams write data in and read data out.
// - Sits between check/variable-node processing units and the extrinsic-message RAM.
// PARAMETERS
// - DATA_WIDTH  8  RAM word width
// - ADDR_WIDTH  8  RAM address width; RAM depth = 1<<ADDR_WIDTH
// - LEN_WIDTH   8  burst length field width; burst = req_len+1 words
// PORTS
// - clk        in   1           clock, all logic on posedge
// - rst_n      in   1           asynchronous active-low reset
// - req_valid  in   1           burst request valid
// - req_ready  out  1           controller idle, request accepted when req_valid&&req_ready
// - req_we     in   1           1 = write burst, 0 = read burst
// - req_addr   in   ADDR_WIDTH  start address
// - req_len    in   LEN_WIDTH   words-1
// - wr_valid   in   1           write word valid
// - wr_ready   out  1           write word accepted when wr_valid&&wr_ready
// - wr_data    in   DATA_WIDTH  write word
// - rd_valid   out  1           read word valid; single-cycle, no backpressure
// - rd_data    out  DATA_WIDTH  read word
// - rd_last    out  1           qualifies the final rd_valid of a burst
// - done       out  1           one-cycle pulse at burst completion
// - ram_cs     out  1           RAM chip select
// - ram_we     out  1           RAM write enable
// - ram_addr   out  ADDR_WIDTH  RAM address
// - ram_wdata  out  DATA_WIDTH  RAM data_in
// - ram_rdata  in   DATA_WIDTH  RAM data_out
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; req_ready, rd_valid, rd_last and done are registered and forced to 0.
//   - ram_cs, ram_we and wr_ready are forced to 0.
//   - Any in-flight burst and pending read word are discarded.
//   - req_ready rises at the first posedge after rst_n deasserts.
// - FSM states:
//   - IDLE: req_ready=1; on accept, latch addr/len/we into cnt; next state WRITE or READ; req_ready=0 from the next cycle.
//   - WRITE: wr_ready=1; ram_cs=wr_valid; ram_we=1; ram_wdata=wr_data; ram_addr=addr reg.
//     - Each accepted word: addr+1, cnt-1.
//     - Accept with cnt==0: next state IDLE, done=1 next cycle.
//     - wr_valid gaps stall the burst with no RAM access.
//   - READ: ram_cs=1, ram_we=0 every cycle; addr+1 and cnt-1 per cycle.
//     - Issue with cnt==0: next state IDLE.
//     - rd_valid is the issue flag delayed 1 cycle; rd_data = ram_rdata (combinational).
//     - Latency: issue edge -> rd_valid in the following cycle.
//     - rd_last and done assert with the last rd_valid.
// - Read bursts issue exactly req_len+1 consecutive accesses; no bubbles, no backpressure.
// - ram_cs=0 in IDLE; outside WRITE, ram_wdata is don't-care but driven to wr_data.
// - Address wraps modulo 2^ADDR_WIDTH (0xFF -> 0x00 for width 8); cnt never underflows.
// - req_ready returns to 1 in the same cycle as done.
// - A new request accepted in that cycle starts the next burst without a bubble.
// - Final rd_valid of a read burst is still delivered when a following write burst has already started.
//   - Safe because the RAM holds data_out while we=1 / cs=0.
// - req_len=0 is a single-word burst.
// - Inputs other than req_* are ignored in IDLE; wr_valid is ignored outside WRITE.
// - rst_n assertion mid-burst aborts immediately; partially written RAM contents are left as is.
// TESTING
// - Reset: rst_n=0 -> all registered outputs 0, ram_cs=0; release -> req_ready=1 after 1 posedge.
// - Write burst addr=0x10 len=3, data AA,BB,CC,DD with 2-cycle wr_valid gap after BB:
//   - RAM writes at 10..13 only on valid cycles; done=1 one cycle after the DD accept; req_ready=1 then.
// - Read burst addr=0x10 len=3 after the above:
//   - ram_cs=1 for 4 consecutive cycles; rd_valid for 4 cycles starting 1 cycle later, data AA,BB,CC,DD.
//   - rd_last and done asserted with DD.
// - Wrap: write addr=0xFE len=3 -> ram_addr FE,FF,00,01; readback returns written words in order.
// - Back-to-back: read len=0 at 0x11, then write request held valid -> accepted on the done cycle.
//   - rd_data=BB still delivered; write proceeds; no lost or duplicated beat.
// - Abort: rst_n=0 during the 3rd beat of a read len=7 -> rd_valid=0 and ram_cs=0 immediately.
//   - No done pulse; after release, a new read len=0 completes normally.

Source files
------------

// File: rtl/ext_ram_burst_ctrl.sv
// Burst controller between the LDPC node processors and the extrinsic-message RAM.
// It accepts one burst request at a time and splits it into single-word accesses
// on a single-port synchronous RAM. That RAM has a 1-cycle registered read.
// Write words stream in through a valid/ready handshake. Read words stream out
// one cycle after each issue, with no backpressure.
module ext_ram_burst_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  req_ready_q, rd_valid_q, rd_last_q, done_q;

    logic wr_acc, rd_iss, last_beat;

    assign wr_acc    = (state_q == S_WRITE) && wr_valid;
    assign rd_iss    = (state_q == S_READ);
    assign last_beat = (cnt_q == '0);

    // A RAM access happens on every accepted write word and on every cycle in READ.
    // Write data always passes straight through, because the RAM ignores it unless ram_we is set.
    assign ram_cs    = wr_acc || rd_iss;
    assign ram_we    = (state_q == S_WRITE);
    assign wr_ready  = (state_q == S_WRITE);
    assign ram_addr  = addr_q;
    assign ram_wdata = wr_data;

    // The RAM holds data_out while it is idle or writing. That makes the read word
    // still valid in the cycle after the last read, even if a new write burst has started.
    assign rd_data   = ram_rdata;
    assign req_ready = req_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign done      = done_q;

    // Next-state logic: latch a request in IDLE, then step addr/cnt once per beat.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    cnt_d   = req_len;
                    state_d = req_we ? S_WRITE : S_READ;
                end
            end
            S_WRITE, S_READ: begin
                if (wr_acc || rd_iss) begin
                    addr_d = addr_q + 1'b1;   // wraps modulo 2^ADDR_WIDTH
                    if (last_beat) state_d = S_IDLE;
                    else           cnt_d   = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered handshake/status outputs.
    // req_ready is high again in the same cycle as done, so the next burst can start without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            req_ready_q <= (state_d == S_IDLE);
            rd_valid_q  <= rd_iss;
            rd_last_q   <= rd_iss && last_beat;
            done_q      <= (rd_iss || wr_acc) && last_beat;
        end
    end

endmodule
